// File: rtl/bit_op_pkg.sv
// Shared definitions for the bit-op datapath: op encoding, default sizes and the
// sequencer FSM state encoding. Used by the single-step mux, the sequencer and the decoder.
package bit_op_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_CNT_W = $clog2(DEF_WIDTH);
    localparam int unsigned OP_W      = 2;

    localparam logic [OP_W-1:0] OP_SHL = 2'd0;
    localparam logic [OP_W-1:0] OP_SHR = 2'd1;
    localparam logic [OP_W-1:0] OP_ROL = 2'd2;
    localparam logic [OP_W-1:0] OP_ROR = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bit_op_sequencer_if.sv
// Request/response bus of the multi-cycle shift/rotate engine.
// master: issue side (drives request fields and out_ready).
// slave : the sequencer (drives in_ready, result fields and busy).
interface bit_op_sequencer_if
    import bit_op_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
);
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic [OP_W-1:0]   in_op;
    logic [CNT_W-1:0]  in_cnt;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic              out_carry;
    logic              out_zero;
    logic              busy;

    modport master (
        output in_valid, in_data, in_op, in_cnt, out_ready,
        input  in_ready, out_valid, out_data, out_carry, out_zero, busy
    );

    modport slave (
        input  in_valid, in_data, in_op, in_cnt, out_ready,
        output in_ready, out_valid, out_data, out_carry, out_zero, busy
    );

endinterface

// File: rtl/bit_op_step.sv
// Single-step bit-op mux: one shift/rotate by one bit position.
// Ports: d (operand), op (SHL/SHR/ROL/ROR) -> next_d (stepped value), bit_out (bit pushed out).
module bit_op_step
    import bit_op_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] d,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] next_d,
    output logic             bit_out
);

    always_comb begin
        next_d  = d;
        bit_out = 1'b0;
        case (op)
            OP_SHL: begin
                next_d  = {d[WIDTH-2:0], 1'b0};
                bit_out = d[WIDTH-1];
            end
            OP_SHR: begin
                next_d  = {1'b0, d[WIDTH-1:1]};
                bit_out = d[0];
            end
            OP_ROL: begin
                next_d  = {d[WIDTH-2:0], d[WIDTH-1]};
                bit_out = d[WIDTH-1];
            end
            OP_ROR: begin
                next_d  = {d[0], d[WIDTH-1:1]};
                bit_out = d[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/bit_op_sequencer.sv
// Multi-cycle shift/rotate engine: steps the single-bit datapath once per clock until the
// requested count is used up, then holds the result until downstream accepts it.
// Ports: clk, rst (async active-high), bus (slave side: request in_*, response out_*, busy).
module bit_op_sequencer
    import bit_op_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    bit_op_sequencer_if.slave     bus
);

    state_t            state;
    state_t            state_nx;
    logic              accept;

    logic [WIDTH-1:0]  data_q;
    logic [OP_W-1:0]   op_q;
    logic [CNT_W-1:0]  rem_q;
    logic              carry_q;
    logic              zero_q;

    logic [WIDTH-1:0]  step_d;
    logic              step_bit;

    // Datapath always steps the held operand; the FSM decides when to take it.
    bit_op_step #(.WIDTH(WIDTH)) u_step (
        .d       (data_q),
        .op      (op_q),
        .next_d  (step_d),
        .bit_out (step_bit)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Next-state decode; cnt=0 skips SHIFT and reports the operand unchanged.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    accept   = 1'b1;
                    state_nx = (bus.in_cnt == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (rem_q == CNT_W'(1)) state_nx = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Operand/result registers; zero flag tracks whatever data holds next.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            op_q    <= '0;
            rem_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else if (accept) begin
            data_q  <= bus.in_data;
            op_q    <= bus.in_op;
            rem_q   <= bus.in_cnt;
            carry_q <= 1'b0;
            zero_q  <= (bus.in_data == '0);
        end else if (state == ST_SHIFT) begin
            data_q  <= step_d;
            carry_q <= step_bit;
            rem_q   <= rem_q - CNT_W'(1);
            zero_q  <= (step_d == '0);
        end
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.busy      = (state == ST_SHIFT) || (state == ST_DONE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.out_data  = data_q;
    assign bus.out_carry = carry_q;
    assign bus.out_zero  = zero_q;

endmodule

// File: tb/tb_bit_op_sequencer.sv
// Directed bench for bit_op_sequencer: vector table plus backpressure and mid-op reset sequences.
module tb_bit_op_sequencer;
    import bit_op_pkg::*;

    localparam int unsigned W  = 16;
    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bit_op_sequencer_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    bit_op_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] data;
        logic [3:0]  cnt;
        logic [15:0] exp_data;
        logic        exp_carry;
        logic        exp_zero;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Wait for in_ready, present one request for exactly the accept edge.
    task automatic send(input logic [1:0] op, input logic [15:0] data, input logic [3:0] cnt);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("accept_timeout", 32'(1'b0), 32'(1'b1));
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_data  = data;
        bus.in_cnt   = cnt;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 16'h0;
    endtask

    // Cycles from the accept edge until out_valid is seen; -1 if it never comes.
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic take_result();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        send(v.op, v.data, v.cnt);
        wait_valid(lat);
        check($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.cnt) + 32'd1);
        check($sformatf("v%0d_data", idx),  32'(bus.out_data),  32'(v.exp_data));
        check($sformatf("v%0d_carry", idx), 32'(bus.out_carry), 32'(v.exp_carry));
        check($sformatf("v%0d_zero", idx),  32'(bus.out_zero),  32'(v.exp_zero));
        take_result();
    endtask

    initial begin
        int  lat;
        bit  seen;
        vec_t post;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 16'h0;
        bus.in_op     = 2'd0;
        bus.in_cnt    = 4'd0;
        bus.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'(1'b0));
        check("rst_in_ready",  32'(bus.in_ready),  32'(1'b1));
        check("rst_busy",      32'(bus.busy),      32'(1'b0));
        check("rst_out_data",  32'(bus.out_data),  32'(16'h0));
        check("rst_carry",     32'(bus.out_carry), 32'(1'b0));
        check("rst_zero",      32'(bus.out_zero),  32'(1'b0));
        rst = 1'b0;

        vecs[0] = '{OP_SHL, 16'h8001, 4'd1,  16'h0002, 1'b1, 1'b0};
        vecs[1] = '{OP_ROR, 16'h0001, 4'd4,  16'h1000, 1'b0, 1'b0};
        vecs[2] = '{OP_SHR, 16'h00F0, 4'd8,  16'h0000, 1'b1, 1'b1};
        vecs[3] = '{OP_ROL, 16'hABCD, 4'd0,  16'hABCD, 1'b0, 1'b0};
        vecs[4] = '{OP_SHL, 16'hFFFF, 4'd15, 16'h8000, 1'b1, 1'b0};
        vecs[5] = '{OP_SHR, 16'h0001, 4'd1,  16'h0000, 1'b1, 1'b1};
        vecs[6] = '{OP_ROR, 16'h12B4, 4'd8,  16'hB412, 1'b1, 1'b0};
        vecs[7] = '{OP_SHL, 16'h0000, 4'd0,  16'h0000, 1'b0, 1'b1};
        vecs[8] = '{OP_SHR, 16'h8000, 4'd15, 16'h0001, 1'b0, 1'b0};
        vecs[9] = '{OP_ROL, 16'h8000, 4'd15, 16'h4000, 1'b0, 1'b0};

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Backpressure: result held, second request ignored until the handshake.
        send(OP_SHL, 16'h0003, 4'd2);
        wait_valid(lat);
        check("bp_latency", 32'(lat), 32'd3);
        bus.in_valid = 1'b1;
        bus.in_op    = OP_SHR;
        bus.in_data  = 16'hFFFF;
        bus.in_cnt   = 4'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp%0d_valid", i),    32'(bus.out_valid), 32'(1'b1));
            check($sformatf("bp%0d_data", i),     32'(bus.out_data),  32'(16'h000C));
            check($sformatf("bp%0d_carry", i),    32'(bus.out_carry), 32'(1'b0));
            check($sformatf("bp%0d_in_ready", i), 32'(bus.in_ready),  32'(1'b0));
            check($sformatf("bp%0d_busy", i),     32'(bus.busy),      32'(1'b1));
        end
        take_result();
        @(negedge clk);
        check("bp_idle_valid",    32'(bus.out_valid), 32'(1'b0));
        check("bp_idle_in_ready", 32'(bus.in_ready),  32'(1'b1));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        wait_valid(lat);
        check("bp2_latency", 32'(lat), 32'd2);
        check("bp2_data",    32'(bus.out_data),  32'(16'h7FFF));
        check("bp2_carry",   32'(bus.out_carry), 32'(1'b1));
        check("bp2_zero",    32'(bus.out_zero),  32'(1'b0));
        take_result();

        // Reset in the 5th SHIFT cycle of a 15-step rotate.
        send(OP_ROL, 16'h8001, 4'd15);
        repeat (5) @(negedge clk);
        check("mid_busy_before", 32'(bus.busy),     32'(1'b1));
        check("mid_ready_before", 32'(bus.in_ready), 32'(1'b0));
        rst = 1'b1;
        #1;
        check("mid_rst_valid",    32'(bus.out_valid), 32'(1'b0));
        check("mid_rst_data",     32'(bus.out_data),  32'(16'h0));
        check("mid_rst_busy",     32'(bus.busy),      32'(1'b0));
        check("mid_rst_in_ready", 32'(bus.in_ready),  32'(1'b1));
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("mid_no_stale_result", 32'(seen), 32'(1'b0));
        post = '{OP_ROR, 16'h0003, 4'd1, 16'h8001, 1'b1, 1'b0};
        run_vec(post, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
